flopr_pipeline: RTL and testbench
=================================

// Module: flopr_pipeline
// PURPOSE
//   Parametrised, elastic register pipeline: DEPTH stages of WIDTH-bit resettable flops with
//   per-stage valid bits and a valid/ready handshake. Bubbles collapse, so a stalled output
//   does not block empty stages behind it. Used to retime long paths in the CPU datapath
//   (e.g. fetch->decode) and to absorb downstream stalls. Supports a synchronous flush.
// PARAMETERS
//   WIDTH        8    data bits per stage
//   DEPTH        4    number of register stages; legal range >= 1
//   RESET_VALUE  0    value loaded into every data register on reset and on flush
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   flush      in   1      synchronous clear of all stages
//   in_valid   in   1      upstream data valid
//   in_ready   out  1      pipeline can accept in_data this cycle
//   in_data    in   WIDTH  upstream data
//   out_valid  out  1      valid bit of the last stage
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  data register of the last stage
// BEHAVIOUR
//   - State per stage i (0..DEPTH-1): valid[i] and data[i]. Stage 0 is the input stage; stage DEPTH-1 drives out_*.
//   - Reset (async): all valid[i]=0; all data[i]=RESET_VALUE. Hence out_valid=0 and out_data=RESET_VALUE.
//     in_ready=1 once reset deasserts, and in_ready=0 while reset is asserted.
//   - Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = !valid[i] || rdy[i+1].
//     in_ready = rdy[0] && !flush && !reset.
//   - Advance: stage i loads from stage i-1 (stage 0 loads from in_*) when rdy[i]=1.
//     - valid[i] <= valid[i-1] (stage 0: in_valid && in_ready).
//     - data[i] is written only when its incoming valid is 1; otherwise data[i] holds.
//     - When rdy[i]=0, the stage holds both valid and data.
//   - Handshakes: a transfer occurs on a clock edge where valid && ready are both 1 on that interface.
//     out_data must stay stable while out_valid=1 && out_ready=0.
//   - Latency: an accepted word appears on out_* exactly DEPTH cycles later if no stall occurs.
//     Throughput is 1 word per cycle with out_ready held at 1.
//   - Capacity: DEPTH words. With out_ready=0, in_ready falls to 0 only when every valid[i]=1 (full).
//     With out_ready=1, in_ready=1 even when full, because simultaneous enqueue and dequeue are allowed.
//   - Bubble collapse: when out_ready=0 and some valid[j]=0, words upstream of j advance, closing the gap.
//   - Flush (sync, highest priority after reset): on the next edge, all valid[i]=0 and all data[i]=RESET_VALUE.
//     in_valid is ignored in the flush cycle, and the word on out_* in the flush cycle is not consumed
//     even if out_ready=1. A flush in the same cycle as a stall is still a full clear.
//   - Reset asserted mid-stream discards all in-flight words immediately; the cycle-level state is not recoverable.
//   - Word order is preserved; no word is duplicated or dropped except by flush or reset.
// CONFIGURATION
//   PIPE_OCCUPANCY_EN
//     - Defined: adds output port occupancy [$clog2(DEPTH+1)-1:0], a registered count of valid stages.
//       Reset and flush set it to 0. It is +1 on an input transfer only, -1 on an output transfer only,
//       and unchanged when both or neither occur. It must always equal popcount(valid).
//     - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//   1. Reset: reset=1 with in_data=8'hAA, in_valid=1 -> out_valid=0, out_data=8'h00, in_ready=0;
//      after release, in_ready=1.
//   2. Streaming (DEPTH=4, out_ready=1): feed 8'h01..8'h08 back-to-back -> 8'h01 on out_* 4 cycles after
//      acceptance, then one word per cycle in order; in_ready is 1 throughout.
//   3. Backpressure: out_ready=0, offer 6 words -> exactly 4 accepted, in_ready=0 after the 4th,
//      out_data=8'h01 stable; raise out_ready -> 8'h01..8'h04 delivered in order.
//   4. Bubble collapse: send 8'h11, idle 2 cycles, send 8'h22 with out_ready=0 -> both occupy the
//      last two stages with no gap; in_ready stays 1.
//   5. Flush: 3 words in flight, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0,
//      all data=RESET_VALUE, the flush-cycle input is lost; the next word sees DEPTH-cycle latency.
//   6. PIPE_OCCUPANCY_EN: run scenarios 3 and 5 -> occupancy reads 4 when full, steps down 3,2,1,0 on drain,
//      and reads 0 the cycle after flush.

Source files
------------

// File: rtl/flopr_pipeline.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit flops with per-stage valid bits,
// valid/ready handshake, bubble collapse and synchronous flush. Define PIPE_OCCUPANCY_EN to add an occupancy counter port.
module flopr_pipeline #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data
`ifdef PIPE_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("flopr_pipeline: DEPTH must be at least 1");
      end
   endgenerate

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];

   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] stage_valid_in;
   logic [WIDTH-1:0] stage_data_in [DEPTH];
   logic             in_fire;
   logic             out_fire;

   // A stage may load when it is empty or when some stage downstream of it
   // (or the consumer) will make room this cycle; this is what collapses bubbles.
   always_comb begin
      logic room;
      // NOTE: room is a blocking temporary inside always_comb; it is assigned before
      // every use, so no latch is inferred and no combinational loop exists on rdy.
      room = out_ready;
      rdy  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         room   = room || !valid[i];
         rdy[i] = room;
      end
   end

   assign in_ready  = rdy[0] && !flush && !reset;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];
   assign out_fire  = out_valid && out_ready && !flush;

   always_comb begin
      stage_valid_in[0] = in_fire;
      stage_data_in[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         stage_valid_in[i] = valid[i-1];
         stage_data_in[i]  = data[i-1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= '0;
         // NOTE: the data array is reset on purpose: out_data must read RESET_VALUE
         // straight out of reset, so these are real flops and not RAM.
         for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VALUE;
      end else if (flush) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VALUE;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
               valid[i] <= stage_valid_in[i];
               // Data only moves with a valid word so an empty slot keeps its old contents.
               if (stage_valid_in[i]) data[i] <= stage_data_in[i];
            end
         end
      end
   end

`ifdef PIPE_OCCUPANCY_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_flopr_pipeline.sv
// Directed bench for flopr_pipeline (DEPTH=4, WIDTH=8): reset, streaming, backpressure,
// bubble collapse and flush, plus occupancy checks when PIPE_OCCUPANCY_EN is defined.
module tb_flopr_pipeline;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
   logic [2:0] occupancy;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   flopr_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_OCCUPANCY_EN
      ,
      .occupancy (occupancy)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_occ(input string tag, input int exp);
`ifdef PIPE_OCCUPANCY_EN
      check(tag, 32'(occupancy), exp);
`endif
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] next_word;
      int         accepted;

      // Reset held with a valid word offered
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_in_ready", in_ready, 0);
      check_occ("rst_occ", 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_release_in_ready", in_ready, 1);
      tick();
      check("rst_no_capture", out_valid, 0);

      // Streaming 01..08 with out_ready=1: first word appears 4 cycles after acceptance
      out_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (c < 8) begin
            in_valid = 1'b1;
            in_data  = 8'(c + 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c < 8) check("stream_in_ready", in_ready, 1);
         if (c >= 4 && c < 12) begin
            check("stream_out_valid", out_valid, 1);
            check("stream_out_data", out_data, c - 3);
         end else begin
            check("stream_out_valid_idle", out_valid, 0);
         end
         tick();
      end

      // Backpressure: offer 6 words with out_ready=0, only 4 fit
      out_ready = 1'b0;
      next_word = 8'h01;
      accepted  = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = next_word;
         #1;
         check("bp_in_ready", in_ready, (c < 4) ? 1 : 0);
         if (c >= 4) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data_stable", out_data, 8'h01);
            check_occ("bp_occ_full", 4);
         end
         if (in_ready) begin
            accepted++;
            next_word++;
         end
         tick();
      end
      check("bp_accepted", accepted, 4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c < 4) begin
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_data", out_data, c + 1);
         end else begin
            check("bp_drain_empty", out_valid, 0);
         end
         check_occ("bp_drain_occ", 4 - c);
         tick();
      end

      // Bubble collapse: 11, two idle cycles, 22, all with out_ready=0
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c == 0 || c == 3);
         in_data  = (c == 0) ? 8'h11 : 8'h22;
         #1;
         check("bub_in_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("bub_out_valid", out_valid, 1);
      check("bub_out_data", out_data, 8'h11);
      check_occ("bub_occ", 2);
      out_ready = 1'b1;
      tick();
      check("bub_second_valid", out_valid, 1);
      check("bub_second_data", out_data, 8'h22);
      tick();
      check("bub_drained", out_valid, 0);

      // Flush with 3 words in flight and a word offered in the flush cycle
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h31 + c);
         tick();
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h44;
      #1;
      check("fl_in_ready_low", in_ready, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("fl_out_valid", out_valid, 0);
      check("fl_out_data", out_data, 8'h00);
      check("fl_in_ready", in_ready, 1);
      check_occ("fl_occ", 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("fl_nothing_leaks", out_valid, 0);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c < 4) begin
            check("fl_lat_wait", out_valid, 0);
            tick();
         end else begin
            check("fl_lat_valid", out_valid, 1);
            check("fl_lat_data", out_data, 8'h55);
         end
      end
      tick();

      // Flush while full and stalled still clears everything
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h66 + c);
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("fs_full_in_ready", in_ready, 0);
      check("fs_full_data", out_data, 8'h66);
      check_occ("fs_occ_full", 4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("fs_out_valid", out_valid, 0);
      check("fs_out_data", out_data, 8'h00);
      check("fs_in_ready", in_ready, 1);
      check_occ("fs_occ", 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
